// File: rtl/fp_div_sched_pkg.sv
// Shared definitions for the FP divider share scheduler:
// operand width helper, index width calc and error flag bit positions.
package fp_div_sched_pkg;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_UNKID     = 1;
    localparam int ERR_OVF       = 2;

    localparam int CNT_W = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    function automatic int op_w(input int sig_w, input int exp_w);
        return sig_w + exp_w + 1;
    endfunction

endpackage

// File: rtl/fp_div_rr_arb.sv
// Round-robin arbiter: picks the first set req bit scanning from ptr upward.
// Ports: req/ptr in; one-hot gnt, its index idx and any-grant flag out.
module fp_div_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr is always < N, so one subtraction wraps the scan
            j = int'(ptr) + k;
            if (j >= N)
                j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fp_div_share_sched.sv
// Shares one pipelined FP divider among NUM_REQ requesters: RR launch, tagged return.
// Ports: req_* / rsp_* requester side, div_* divider side, busy and err_sticky status.
module fp_div_share_sched
    import fp_div_sched_pkg::*;
#(
    parameter  int SIG_W   = 23,
    parameter  int EXP_W   = 8,
    parameter  int NUM_REQ = 4,
    parameter  int ID_W    = 8,
    parameter  int MAX_OUT = 3,
    localparam int W       = op_w(SIG_W, EXP_W),
    localparam int IDX_W   = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_rnd,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_z,
    output logic [7:0]           rsp_status,
    output logic                 div_launch,
    output logic [ID_W-1:0]      div_launch_id,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    output logic [2:0]           div_rnd,
    input  logic                 div_pipe_full,
    input  logic                 div_pipe_ovf,
    input  logic                 div_arrive,
    input  logic [ID_W-1:0]      div_arrive_id,
    input  logic [W-1:0]         div_z,
    input  logic [7:0]           div_status,
    output logic                 div_accept_n,
    output logic                 busy,
    output logic [2:0]           err_sticky
);

    logic [CNT_W-1:0] cnt [NUM_REQ];
    logic [IDX_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gidx;
    logic               gany;

    logic [IDX_W-1:0]   ret_idx;
    logic               id_ok;
    logic [NUM_REQ-1:0] hs;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
    end

    assign arb_req = div_pipe_full ? '0 : elig;

    fp_div_rr_arb #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    assign req_ready     = gnt;
    assign div_launch    = gany;
    assign div_launch_id = ID_W'(gidx);

    // gnt is one-hot or zero, so an OR of masked fields is the mux
    always_comb begin
        div_a   = '0;
        div_b   = '0;
        div_rnd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                div_a   = div_a   | req_a[i*W +: W];
                div_b   = div_b   | req_b[i*W +: W];
                div_rnd = div_rnd | req_rnd[i*3 +: 3];
            end
        end
    end

    assign ret_idx = div_arrive_id[IDX_W-1:0];
    assign id_ok   = ((div_arrive_id >> IDX_W) == '0)
                  && (int'(ret_idx) < NUM_REQ);

    // Unknown tags are discarded (accept_n stays low) rather than stalling
    always_comb begin
        rsp_valid    = '0;
        div_accept_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (div_arrive && id_ok && (ret_idx == IDX_W'(i))) begin
                rsp_valid[i] = 1'b1;
                div_accept_n = ~rsp_ready[i];
            end
        end
    end

    assign rsp_z      = div_z;
    assign rsp_status = div_status;
    assign hs         = rsp_valid & rsp_ready;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            busy = busy | (cnt[i] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            err_sticky <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                cnt[i] <= '0;
        end else begin
            if (gany) begin
                if (gidx == IDX_W'(NUM_REQ - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= gidx + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && !hs[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (hs[i] && !gnt[i]) begin
                    if (cnt[i] == '0)
                        err_sticky[ERR_UNDERFLOW] <= 1'b1;
                    else
                        cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (div_arrive && !id_ok)
                err_sticky[ERR_UNKID] <= 1'b1;
            if (div_pipe_ovf)
                err_sticky[ERR_OVF] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_div_share_sched.sv
// Directed bench for fp_div_share_sched: vector table for launch/return
// paths plus hand sequences for credit limit, same-cycle grant/response, errors, reset.
module tb_fp_div_share_sched;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*3-1:0]   req_rnd;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_z;
    logic [7:0]       rsp_status;
    logic             div_launch;
    logic [IDW-1:0]   div_launch_id;
    logic [W-1:0]     div_a;
    logic [W-1:0]     div_b;
    logic [2:0]       div_rnd;
    logic             div_pipe_full;
    logic             div_pipe_ovf;
    logic             div_arrive;
    logic [IDW-1:0]   div_arrive_id;
    logic [W-1:0]     div_z;
    logic [7:0]       div_status;
    logic             div_accept_n;
    logic             busy;
    logic [2:0]       err_sticky;

    fp_div_share_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_rnd       (req_rnd),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_z         (rsp_z),
        .rsp_status    (rsp_status),
        .div_launch    (div_launch),
        .div_launch_id (div_launch_id),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_rnd       (div_rnd),
        .div_pipe_full (div_pipe_full),
        .div_pipe_ovf  (div_pipe_ovf),
        .div_arrive    (div_arrive),
        .div_arrive_id (div_arrive_id),
        .div_z         (div_z),
        .div_status    (div_status),
        .div_accept_n  (div_accept_n),
        .busy          (busy),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] rv;
        logic       full;
        logic       arr;
        logic [7:0] aid;
        logic [3:0] rr;
        logic [3:0] e_ready;
        logic       e_launch;
        logic [7:0] e_id;
        logic [3:0] e_rsp;
        logic       e_accn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [3:0] rv, input logic full, input logic arr,
        input logic [7:0] aid, input logic [3:0] rr,
        input logic [3:0] e_ready, input logic e_launch,
        input logic [7:0] e_id, input logic [3:0] e_rsp,
        input logic e_accn);
        vec_t v;
        v.rv = rv; v.full = full; v.arr = arr; v.aid = aid; v.rr = rr;
        v.e_ready = e_ready; v.e_launch = e_launch; v.e_id = e_id;
        v.e_rsp = e_rsp; v.e_accn = e_accn;
        return v;
    endfunction

    function automatic logic [31:0] opa(input int i);
        return 32'h3F80_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] opb(input int i);
        return 32'h4000_0100 + 32'(i);
    endfunction

    function automatic logic [2:0] opr(input int i);
        return 3'(i + 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] rv, input logic full,
                        input logic arr, input logic [7:0] aid,
                        input logic [3:0] rr);
        @(negedge clk);
        req_valid     = rv;
        div_pipe_full = full;
        div_arrive    = arr;
        div_arrive_id = aid;
        rsp_ready     = rr;
        div_z         = 32'hC0DE_0000 | 32'(aid);
        div_status    = aid ^ 8'h5A;
        #1;
    endtask

    task automatic idle();
        step(4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        rsp_ready     = '0;
        div_pipe_full = 1'b0;
        div_pipe_ovf  = 1'b0;
        div_arrive    = 1'b0;
        div_arrive_id = '0;
        div_z         = '0;
        div_status    = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]   = opa(i);
            req_b[i*W +: W]   = opb(i);
            req_rnd[i*3 +: 3] = opr(i);
        end

        // Launch / return vectors; rr_ptr and credits tracked by hand
        tbl.push_back(mk(4'hF, 0, 0, 8'd0, 4'hF, 4'b0001, 1, 8'd0, 4'h0, 0));
        tbl.push_back(mk(4'hF, 0, 0, 8'd0, 4'hF, 4'b0010, 1, 8'd1, 4'h0, 0));
        tbl.push_back(mk(4'hF, 0, 0, 8'd0, 4'hF, 4'b0100, 1, 8'd2, 4'h0, 0));
        tbl.push_back(mk(4'hF, 0, 0, 8'd0, 4'hF, 4'b1000, 1, 8'd3, 4'h0, 0));
        tbl.push_back(mk(4'hF, 0, 0, 8'd0, 4'hF, 4'b0001, 1, 8'd0, 4'h0, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd0, 4'hF, 4'b0000, 0, 8'd0, 4'b0001, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd1, 4'hF, 4'b0000, 0, 8'd0, 4'b0010, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd2, 4'hF, 4'b0000, 0, 8'd0, 4'b0100, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd3, 4'hF, 4'b0000, 0, 8'd0, 4'b1000, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd0, 4'hF, 4'b0000, 0, 8'd0, 4'b0001, 0));
        // pipe full holds the pointer at 1, release resumes there
        tbl.push_back(mk(4'hF, 1, 0, 8'd0, 4'hF, 4'b0000, 0, 8'd0, 4'h0, 0));
        tbl.push_back(mk(4'hF, 0, 0, 8'd0, 4'hF, 4'b0010, 1, 8'd1, 4'h0, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd1, 4'hF, 4'b0000, 0, 8'd0, 4'b0010, 0));
        // unknown ids: 9 is out of range, 0x10 has upper bits set
        tbl.push_back(mk(4'h0, 0, 1, 8'd9, 4'hF, 4'b0000, 0, 8'd0, 4'b0000, 0));
        tbl.push_back(mk(4'h1, 0, 1, 8'h10, 4'hF, 4'b0001, 1, 8'd0, 4'b0000, 0));
        tbl.push_back(mk(4'h0, 0, 1, 8'd0, 4'hF, 4'b0000, 0, 8'd0, 4'b0001, 0));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst err", 64'(err_sticky), 64'd0);
        chk("rst ready", 64'(req_ready), 64'd0);
        chk("rst launch", 64'(div_launch), 64'd0);
        rst_n = 1'b1;
        idle();
        chk("idle ready", 64'(req_ready), 64'd0);
        chk("idle launch", 64'(div_launch), 64'd0);
        chk("idle rsp", 64'(rsp_valid), 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            logic [31:0] ea, eb;
            logic [2:0]  er;
            v  = tbl[i];
            ea = v.e_launch ? opa(int'(v.e_id)) : 32'h0;
            eb = v.e_launch ? opb(int'(v.e_id)) : 32'h0;
            er = v.e_launch ? opr(int'(v.e_id)) : 3'h0;
            step(v.rv, v.full, v.arr, v.aid, v.rr);
            chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(v.e_ready));
            chk($sformatf("v%0d launch", i), 64'(div_launch), 64'(v.e_launch));
            if (v.e_launch)
                chk($sformatf("v%0d id", i), 64'(div_launch_id), 64'(v.e_id));
            chk($sformatf("v%0d div_a", i), 64'(div_a), 64'(ea));
            chk($sformatf("v%0d div_b", i), 64'(div_b), 64'(eb));
            chk($sformatf("v%0d div_rnd", i), 64'(div_rnd), 64'(er));
            chk($sformatf("v%0d rsp", i), 64'(rsp_valid), 64'(v.e_rsp));
            chk($sformatf("v%0d accn", i), 64'(div_accept_n), 64'(v.e_accn));
            if (v.arr)
                chk($sformatf("v%0d z", i), 64'(rsp_z),
                    64'(32'hC0DE_0000 | 32'(v.aid)));
        end
        idle();
        chk("after tbl busy", 64'(busy), 64'd0);
        chk("unkid err", 64'(err_sticky), 64'b010);

        // credit limit on requester 1, rr_ptr now 1
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 1'b0, 1'b0, 8'd0, 4'b0000);
            chk($sformatf("cap grant%0d", k), 64'(req_ready), 64'b0010);
        end
        step(4'b0010, 1'b0, 1'b1, 8'd1, 4'b0000);
        chk("cap blocked", 64'(req_ready), 64'd0);
        chk("cap no launch", 64'(div_launch), 64'd0);
        chk("hold rsp", 64'(rsp_valid), 64'b0010);
        chk("hold accn", 64'(div_accept_n), 64'd1);
        chk("cap busy", 64'(busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 1'b0, 1'b1, 8'd1, 4'b0010);
            chk($sformatf("drain rsp%0d", k), 64'(rsp_valid), 64'b0010);
            chk($sformatf("drain accn%0d", k), 64'(div_accept_n), 64'd0);
            chk($sformatf("drain busy%0d", k), 64'(busy), 64'd1);
        end
        idle();
        chk("drained busy", 64'(busy), 64'd0);

        // same-cycle grant and response on requester 2, rr_ptr now 2
        step(4'b0100, 1'b0, 1'b0, 8'd0, 4'b0000);
        chk("g2 first", 64'(req_ready), 64'b0100);
        step(4'b0100, 1'b0, 1'b1, 8'd2, 4'b0100);
        chk("g2 both ready", 64'(req_ready), 64'b0100);
        chk("g2 both rsp", 64'(rsp_valid), 64'b0100);
        idle();
        chk("g2 cnt kept", 64'(busy), 64'd1);
        step(4'b0000, 1'b0, 1'b1, 8'd2, 4'b0100);
        idle();
        chk("g2 cnt zero", 64'(busy), 64'd0);
        chk("g2 no err", 64'(err_sticky), 64'b010);

        // response with zero credit, then divider overflow
        step(4'b0000, 1'b0, 1'b1, 8'd0, 4'b0001);
        idle();
        chk("underflow err", 64'(err_sticky), 64'b011);
        chk("underflow busy", 64'(busy), 64'd0);
        @(negedge clk);
        div_pipe_ovf = 1'b1;
        @(negedge clk);
        div_pipe_ovf = 1'b0;
        #1;
        chk("ovf err", 64'(err_sticky), 64'b111);

        // reset with three ops in flight
        for (int k = 0; k < 3; k++)
            step(4'hF, 1'b0, 1'b0, 8'd0, 4'b0000);
        idle();
        chk("inflight busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst err", 64'(err_sticky), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post rst busy", 64'(busy), 64'd0);
        chk("post rst launch", 64'(div_launch), 64'd0);
        step(4'b1000, 1'b0, 1'b0, 8'd0, 4'b0000);
        chk("post rst ptr", 64'(div_launch_id), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
